// File: rtl/ervp_platform_watchdog_pkg.sv
// Shared definitions for the platform watchdog: memory map, bit indices,
// FSM encoding, default kick key and the bus endian conversion helper.
package ervp_platform_watchdog_pkg;

  localparam int LITTLE_ENDIAN = 0;
  localparam int BIG_ENDIAN    = 1;

  localparam logic [4:0] MMAP_SUBOFFSET_WDT_CTRL   = 5'h00;
  localparam logic [4:0] MMAP_SUBOFFSET_WDT_LOAD   = 5'h04;
  localparam logic [4:0] MMAP_SUBOFFSET_WDT_WARN   = 5'h08;
  localparam logic [4:0] MMAP_SUBOFFSET_WDT_KICK   = 5'h0C;
  localparam logic [4:0] MMAP_SUBOFFSET_WDT_STATUS = 5'h10;
  localparam logic [4:0] MMAP_SUBOFFSET_WDT_COUNT  = 5'h14;

  localparam logic [2:0] WDT_WORD_CTRL   = MMAP_SUBOFFSET_WDT_CTRL[4:2];
  localparam logic [2:0] WDT_WORD_LOAD   = MMAP_SUBOFFSET_WDT_LOAD[4:2];
  localparam logic [2:0] WDT_WORD_WARN   = MMAP_SUBOFFSET_WDT_WARN[4:2];
  localparam logic [2:0] WDT_WORD_KICK   = MMAP_SUBOFFSET_WDT_KICK[4:2];
  localparam logic [2:0] WDT_WORD_STATUS = MMAP_SUBOFFSET_WDT_STATUS[4:2];
  localparam logic [2:0] WDT_WORD_COUNT  = MMAP_SUBOFFSET_WDT_COUNT[4:2];

  localparam int CTRL_ENABLE          = 0;
  localparam int CTRL_RESET_EN        = 1;
  localparam int CTRL_IRQ_EN          = 2;
  localparam int STATUS_WARN_PEND     = 0;
  localparam int STATUS_TIMEOUT_SEEN  = 1;
  localparam int STATUS_BAD_KICK      = 2;
  localparam int STATUS_RESET_CAUSED  = 3;

  localparam logic [31:0] WDT_DEFAULT_KICK_KEY = 32'h5A5A_A5A5;

  typedef enum logic [1:0] {
    WDT_STATE_IDLE,
    WDT_STATE_COUNT,
    WDT_STATE_WARN,
    WDT_STATE_FIRE
  } wdt_state_e;

  typedef struct packed {
    logic reset_caused;
    logic timeout_seen;
    logic warn_pend;
  } wdt_hw_set_t;

  function automatic logic [31:0] endian_convert(input logic [31:0] data, input int endian);
    if (endian == BIG_ENDIAN) return {data[7:0], data[15:8], data[23:16], data[31:24]};
    return data;
  endfunction

endpackage

// File: rtl/ervp_wdt_register_file.sv
// Watchdog register file: bus decode, CTRL/LOAD/WARN/STATUS storage with
// write-1-to-clear status, kick key check and data endian conversion.
module ervp_wdt_register_file
  import ervp_platform_watchdog_pkg::*;
#(
  parameter int          BW_COUNTER = 32,
  parameter logic [31:0] KICK_KEY   = WDT_DEFAULT_KICK_KEY,
  parameter int          ENDIAN     = LITTLE_ENDIAN
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  rpsel,
  input  logic                  rpenable,
  input  logic [31:0]           rpaddr,
  input  logic                  rpwrite,
  input  logic [31:0]           rpwdata,
  output logic [31:0]           rprdata,
  output logic                  rpready,
  output logic                  rpslverr,
  input  logic                  fire_active,
  input  logic                  clear_enable,
  input  wdt_hw_set_t           hw_set,
  input  logic [BW_COUNTER-1:0] count,
  output logic                  ctrl_enable,
  output logic                  ctrl_reset_en,
  output logic                  ctrl_irq_en,
  output logic [BW_COUNTER-1:0] load,
  output logic [BW_COUNTER-1:0] warn,
  output logic [3:0]            status,
  output logic                  enable_rise,
  output logic                  disable_req,
  output logic                  kick_ok
);

  logic [2:0]            ctrl_q, ctrl_d;
  logic [BW_COUNTER-1:0] load_q, load_d;
  logic [BW_COUNTER-1:0] warn_q, warn_d;
  logic [3:0]            status_q, status_d;
  logic [31:0]           wdata, rdata_raw;
  logic [2:0]            word;
  logic                  wr_en, addr_ok, kick_wr, bad_kick;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{rpaddr[31:5], rpaddr[1:0]};

  assign word        = rpaddr[4:2];
  assign wr_en       = rpsel & rpenable & rpwrite;
  assign wdata       = endian_convert(rpwdata, ENDIAN);
  assign kick_wr     = wr_en && (word == WDT_WORD_KICK) && !fire_active;
  assign kick_ok     = kick_wr && (wdata == KICK_KEY);
  assign bad_kick    = kick_wr && (wdata != KICK_KEY);
  assign enable_rise = wr_en && (word == WDT_WORD_CTRL) && wdata[CTRL_ENABLE] && !ctrl_q[CTRL_ENABLE];
  assign disable_req = wr_en && (word == WDT_WORD_CTRL) && !wdata[CTRL_ENABLE];

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    ctrl_d   = ctrl_q;
    load_d   = load_q;
    warn_d   = warn_q;
    status_d = status_q;
    if (wr_en) begin
      case (word)
        WDT_WORD_CTRL:   ctrl_d   = wdata[2:0];
        WDT_WORD_LOAD:   load_d   = wdata[BW_COUNTER-1:0];
        WDT_WORD_WARN:   warn_d   = wdata[BW_COUNTER-1:0];
        WDT_WORD_STATUS: status_d = status_q & ~wdata[3:0];
        default: ;
      endcase
    end
    // Hardware events are applied after the software update so they win.
    if (clear_enable) ctrl_d[CTRL_ENABLE] = 1'b0;
    if (hw_set.warn_pend)    status_d[STATUS_WARN_PEND]    = 1'b1;
    if (hw_set.timeout_seen) status_d[STATUS_TIMEOUT_SEEN] = 1'b1;
    if (hw_set.reset_caused) status_d[STATUS_RESET_CAUSED] = 1'b1;
    if (bad_kick)            status_d[STATUS_BAD_KICK]     = 1'b1;
  end

  always_comb begin
    rdata_raw = '0;
    addr_ok   = 1'b1;
    case (word)
      WDT_WORD_CTRL:   rdata_raw = 32'(ctrl_q);
      WDT_WORD_LOAD:   rdata_raw = 32'(load_q);
      WDT_WORD_WARN:   rdata_raw = 32'(warn_q);
      WDT_WORD_KICK:   rdata_raw = '0;
      WDT_WORD_STATUS: rdata_raw = 32'(status_q);
      WDT_WORD_COUNT:  rdata_raw = 32'(count);
      default:         addr_ok   = 1'b0;
    endcase
  end

  assign rprdata  = endian_convert(rdata_raw, ENDIAN);
  assign rpready  = 1'b1;
  assign rpslverr = rpsel & ~addr_ok;

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      ctrl_q   <= '0;
      load_q   <= '1;
      warn_q   <= '0;
      status_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      load_q   <= load_d;
      warn_q   <= warn_d;
      status_q <= status_d;
    end
  end

  assign ctrl_enable   = ctrl_q[CTRL_ENABLE];
  assign ctrl_reset_en = ctrl_q[CTRL_RESET_EN];
  assign ctrl_irq_en   = ctrl_q[CTRL_IRQ_EN];
  assign load          = load_q;
  assign warn          = warn_q;
  assign status        = status_q;

endmodule

// File: rtl/ervp_platform_watchdog.sv
// Platform watchdog top: countdown FSM, warning interrupt and the held
// active-low reset request feeding the platform reset controller.
module ervp_platform_watchdog
  import ervp_platform_watchdog_pkg::*;
#(
  parameter int          BW_COUNTER        = 32,
  parameter int          RESET_HOLD_CYCLES = 16,
  parameter logic [31:0] KICK_KEY          = WDT_DEFAULT_KICK_KEY,
  parameter int          ENDIAN            = LITTLE_ENDIAN
) (
  input  logic        clk,
  input  logic        rstnn,
  input  logic        rpsel,
  input  logic        rpenable,
  input  logic [31:0] rpaddr,
  input  logic        rpwrite,
  input  logic [31:0] rpwdata,
  output logic [31:0] rprdata,
  output logic        rpready,
  output logic        rpslverr,
  output logic        wdt_irq,
  output logic        wdt_reset_req_nn
);

  localparam int BW_HOLD = $clog2(RESET_HOLD_CYCLES + 1);

  wdt_state_e            state_q, state_d;
  logic [BW_COUNTER-1:0] count_q, count_d, eff_load, load, warn;
  logic [BW_HOLD-1:0]    hold_q, hold_d;
  logic                  reset_req_nn_q, reset_req_nn_d;
  logic                  ctrl_enable, ctrl_reset_en, ctrl_irq_en;
  logic                  enable_rise, disable_req, kick_ok, clear_enable;
  logic [3:0]            status;
  wdt_hw_set_t           hw_set;

  ervp_wdt_register_file #(
    .BW_COUNTER(BW_COUNTER),
    .KICK_KEY  (KICK_KEY),
    .ENDIAN    (ENDIAN)
  ) u_regs (
    .clk          (clk),
    .rstnn        (rstnn),
    .rpsel        (rpsel),
    .rpenable     (rpenable),
    .rpaddr       (rpaddr),
    .rpwrite      (rpwrite),
    .rpwdata      (rpwdata),
    .rprdata      (rprdata),
    .rpready      (rpready),
    .rpslverr     (rpslverr),
    .fire_active  (state_q == WDT_STATE_FIRE),
    .clear_enable (clear_enable),
    .hw_set       (hw_set),
    .count        (count_q),
    .ctrl_enable  (ctrl_enable),
    .ctrl_reset_en(ctrl_reset_en),
    .ctrl_irq_en  (ctrl_irq_en),
    .load         (load),
    .warn         (warn),
    .status       (status),
    .enable_rise  (enable_rise),
    .disable_req  (disable_req),
    .kick_ok      (kick_ok)
  );

  assign eff_load = (load == '0) ? BW_COUNTER'(1) : load;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    hold_d       = hold_q;
    hw_set       = '0;
    clear_enable = 1'b0;
    case (state_q)
      WDT_STATE_IDLE: begin
        if (enable_rise || (kick_ok && ctrl_enable)) begin
          count_d = eff_load;
          state_d = WDT_STATE_COUNT;
        end
      end
      WDT_STATE_COUNT, WDT_STATE_WARN: begin
        if (disable_req) begin
          state_d = WDT_STATE_IDLE;
        end else if (kick_ok) begin
          count_d = eff_load;
          state_d = WDT_STATE_COUNT;
        end else if (count_q <= BW_COUNTER'(1)) begin
          if (ctrl_reset_en) begin
            state_d = WDT_STATE_FIRE;
            hold_d  = BW_HOLD'(RESET_HOLD_CYCLES);
          end else begin
            hw_set.timeout_seen = 1'b1;
            count_d             = eff_load;
            state_d             = WDT_STATE_COUNT;
          end
        end else begin
          count_d = count_q - 1'b1;
          if (state_q == WDT_STATE_COUNT && count_d <= warn) begin
            state_d          = WDT_STATE_WARN;
            hw_set.warn_pend = 1'b1;
          end
        end
      end
      WDT_STATE_FIRE: begin
        // Bus disables are ignored here: a started request always runs its full length.
        hold_d = hold_q - 1'b1;
        if (hold_q <= BW_HOLD'(1)) begin
          state_d             = WDT_STATE_IDLE;
          clear_enable        = 1'b1;
          hw_set.reset_caused = 1'b1;
        end
      end
      default: state_d = WDT_STATE_IDLE;
    endcase
    reset_req_nn_d = (state_d != WDT_STATE_FIRE);
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state_q        <= WDT_STATE_IDLE;
      count_q        <= '1;
      hold_q         <= '0;
      reset_req_nn_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      hold_q         <= hold_d;
      reset_req_nn_q <= reset_req_nn_d;
    end
  end

  assign wdt_irq          = ctrl_irq_en & status[STATUS_WARN_PEND];
  assign wdt_reset_req_nn = reset_req_nn_q;

endmodule

// File: tb/tb_ervp_platform_watchdog.sv
// Self-checking bench for ervp_platform_watchdog: bus reads are checked by a
// scoreboard monitor; pin-level timing is checked directly against hand counts.
module tb_ervp_platform_watchdog;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_LOAD   = 32'h04;
  localparam logic [31:0] A_WARN   = 32'h08;
  localparam logic [31:0] A_KICK   = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;
  localparam logic [31:0] A_COUNT  = 32'h14;
  localparam logic [31:0] KEY      = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rstnn = 1'b0;
  logic        rpsel = 1'b0, rpenable = 1'b0, rpwrite = 1'b0;
  logic [31:0] rpaddr = '0, rpwdata = '0;
  logic [31:0] rprdata;
  logic        rpready, rpslverr, wdt_irq, wdt_reset_req_nn;

  typedef struct {
    logic [31:0] data;
    logic        slverr;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   low_run = 0;
  int   last_pulse = 0;
  int   pulses = 0;

  ervp_platform_watchdog dut (
    .clk             (clk),
    .rstnn           (rstnn),
    .rpsel           (rpsel),
    .rpenable        (rpenable),
    .rpaddr          (rpaddr),
    .rpwrite         (rpwrite),
    .rpwdata         (rpwdata),
    .rprdata         (rprdata),
    .rpready         (rpready),
    .rpslverr        (rpslverr),
    .wdt_irq         (wdt_irq),
    .wdt_reset_req_nn(wdt_reset_req_nn)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every read access phase against the queue head.
  always @(negedge clk) begin
    if (rpsel && rpenable && !rpwrite) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", rprdata, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, rprdata, e.data);
        check({e.name, "_slverr"}, 32'(rpslverr), 32'(e.slverr));
      end
    end
  end

  // Measures the width of each low pulse on the reset request.
  always @(negedge clk) begin
    if (!wdt_reset_req_nn) begin
      low_run++;
    end else if (low_run != 0) begin
      last_pulse = low_run;
      pulses++;
      low_run = 0;
    end
  end

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    rpsel = 1'b1; rpenable = 1'b0; rpwrite = 1'b1; rpaddr = addr; rpwdata = data;
    @(posedge clk); #1;
    rpenable = 1'b1;
    @(posedge clk); #1;
    rpsel = 1'b0; rpenable = 1'b0; rpwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input logic err,
                          input string name);
    exp_t e;
    e.data = exp; e.slverr = err; e.name = name;
    exp_q.push_back(e);
    @(posedge clk); #1;
    rpsel = 1'b1; rpenable = 1'b0; rpwrite = 1'b0; rpaddr = addr;
    @(posedge clk); #1;
    rpenable = 1'b1;
    @(posedge clk); #1;
    rpsel = 1'b0; rpenable = 1'b0;
  endtask

  task automatic wait_pulse(input string name, input int exp_len);
    int start;
    start = pulses;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pulses != start) break;
    end
    check({name, "_seen"}, 32'(pulses - start), 32'd1);
    check({name, "_len"}, 32'(last_pulse), 32'(exp_len));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_nn", 32'(wdt_reset_req_nn), 32'd1);
    check("rst_irq", 32'(wdt_irq), 32'd0);
    check("rst_ready", 32'(rpready), 32'd1);
    rstnn = 1'b1;
    apb_read(A_LOAD, 32'hFFFF_FFFF, 1'b0, "rst_load");
    apb_read(A_COUNT, 32'hFFFF_FFFF, 1'b0, "rst_count");

    // 1: unkicked expiry with reset enabled
    apb_write(A_LOAD, 32'd10);
    apb_write(A_WARN, 32'd3);
    apb_write(A_CTRL, 32'h7);
    repeat (6) @(posedge clk);
    #1 check("t1_irq_before", 32'(wdt_irq), 32'd0);
    @(posedge clk);
    #1 check("t1_irq_rise", 32'(wdt_irq), 32'd1);
    repeat (2) @(posedge clk);
    #1 check("t1_req_before", 32'(wdt_reset_req_nn), 32'd1);
    @(posedge clk);
    #1 check("t1_req_fall", 32'(wdt_reset_req_nn), 32'd0);
    wait_pulse("t1_pulse", 16);
    apb_read(A_STATUS, 32'h9, 1'b0, "t1_status");
    apb_read(A_CTRL, 32'h6, 1'b0, "t1_ctrl");
    apb_read(A_COUNT, 32'd1, 1'b0, "t1_count");
    apb_write(A_STATUS, 32'hF);
    apb_read(A_STATUS, 32'h0, 1'b0, "t1_status_clr");
    check("t1_irq_clr", 32'(wdt_irq), 32'd0);

    // 2: periodic valid kicks keep the watchdog quiet
    apb_write(A_CTRL, 32'h7);
    for (int k = 0; k < 16; k++) begin
      repeat (3) @(posedge clk);
      apb_write(A_KICK, KEY);
      check("t2_irq", 32'(wdt_irq), 32'd0);
      check("t2_req", 32'(wdt_reset_req_nn), 32'd1);
    end
    apb_read(A_COUNT, 32'd8, 1'b0, "t2_count");
    apb_read(A_STATUS, 32'h0, 1'b0, "t2_status");
    apb_write(A_CTRL, 32'h0);
    apb_write(A_STATUS, 32'hF);

    // 3: wrong key flags bad_kick without reloading
    apb_write(A_LOAD, 32'd100);
    apb_write(A_WARN, 32'd0);
    apb_write(A_CTRL, 32'h1);
    apb_write(A_KICK, 32'h1234_5678);
    apb_read(A_COUNT, 32'd95, 1'b0, "t3_count");
    apb_read(A_STATUS, 32'h4, 1'b0, "t3_status");
    apb_write(A_STATUS, 32'h4);
    apb_read(A_STATUS, 32'h0, 1'b0, "t3_status_clr");
    apb_read(A_KICK, 32'h0, 1'b0, "t3_kick_rd");
    apb_write(A_CTRL, 32'h0);

    // 4: expiry with reset disabled reloads and flags timeout
    apb_write(A_LOAD, 32'd5);
    apb_write(A_CTRL, 32'h1);
    apb_read(A_STATUS, 32'h0, 1'b0, "t4_status_early");
    apb_read(A_STATUS, 32'h2, 1'b0, "t4_status");
    apb_read(A_COUNT, 32'd2, 1'b0, "t4_count_reload");
    check("t4_req", 32'(wdt_reset_req_nn), 32'd1);
    apb_write(A_CTRL, 32'h0);
    apb_write(A_STATUS, 32'hF);

    // 5: kick in the expiry cycle, then disable attempt during FIRE
    apb_write(A_CTRL, 32'h3);
    repeat (2) @(posedge clk);
    apb_write(A_KICK, KEY);
    apb_read(A_COUNT, 32'd3, 1'b0, "t5_count_kick");
    check("t5_req_kick", 32'(wdt_reset_req_nn), 32'd1);
    apb_write(A_CTRL, 32'h0);
    wait_pulse("t5_pulse", 16);
    apb_read(A_CTRL, 32'h0, 1'b0, "t5_ctrl");
    apb_read(A_STATUS, 32'h8, 1'b0, "t5_status");
    apb_write(A_STATUS, 32'hF);

    // 6: unmapped offsets, then reset while the request is active
    apb_read(32'h18, 32'h0, 1'b1, "t6_unmapped_18");
    apb_read(32'h1C, 32'h0, 1'b1, "t6_unmapped_1c");
    apb_write(A_WARN, 32'd2);
    apb_write(A_CTRL, 32'h7);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!wdt_reset_req_nn) break;
    end
    check("t6_fire", 32'(wdt_reset_req_nn), 32'd0);
    repeat (3) @(posedge clk);
    #1 rstnn = 1'b0;
    @(posedge clk);
    #1;
    check("t6_rst_req", 32'(wdt_reset_req_nn), 32'd1);
    check("t6_rst_irq", 32'(wdt_irq), 32'd0);
    rstnn = 1'b1;
    apb_read(A_CTRL, 32'h0, 1'b0, "t6_ctrl");
    apb_read(A_LOAD, 32'hFFFF_FFFF, 1'b0, "t6_load");
    apb_read(A_WARN, 32'h0, 1'b0, "t6_warn");
    apb_read(A_STATUS, 32'h0, 1'b0, "t6_status");
    apb_read(A_COUNT, 32'hFFFF_FFFF, 1'b0, "t6_count");
    repeat (20) @(posedge clk);
    #1 check("t6_req_idle", 32'(wdt_reset_req_nn), 32'd1);

    repeat (2) @(posedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
